// File: rtl/dqn_pkg.sv
// Shared DQN datapath definitions: the fp32 word type, fp32 constants, a NaN test
// and the exploration LFSR seed/taps.
package dqn_pkg;

  localparam int DATA_WIDTH = 32;

  typedef logic [DATA_WIDTH-1:0] fp32_t;

  localparam fp32_t FP32_NEG_INF  = 32'hFF80_0000;
  localparam fp32_t FP32_POS_ZERO = 32'h0000_0000;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic is_nan(input fp32_t x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/fp32_gt.sv
// Combinational fp32 "a beats b": ordered compare with -0 == +0 and denormals
// compared as-is. A NaN never wins, and any non-NaN beats a NaN.
module fp32_gt
  import dqn_pkg::*;
(
  input  fp32_t a,
  input  fp32_t b,
  output logic  gt
);

  logic  a_nan, b_nan, both_zero;
  fp32_t key_a, key_b;

  // Map sign-magnitude onto an unsigned total order so a plain compare works.
  assign key_a     = a[31] ? ~a : {1'b1, a[30:0]};
  assign key_b     = b[31] ? ~b : {1'b1, b[30:0]};
  assign a_nan     = is_nan(a);
  assign b_nan     = is_nan(b);
  assign both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);

  always_comb begin
    if (a_nan)          gt = 1'b0;
    else if (b_nan)     gt = 1'b1;
    else if (both_zero) gt = 1'b0;
    else                gt = key_a > key_b;
  end

endmodule

// File: rtl/q_action_select.sv
// Greedy action selection over a stream of NUM_ACTIONS fp32 Q-values.
// Optional epsilon-greedy exploration is built when ACTION_EPSILON_GREEDY_EN is defined.
module q_action_select
  import dqn_pkg::*;
#(
  parameter  int NUM_ACTIONS = 3,
  localparam int ACT_W       = $clog2(NUM_ACTIONS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [15:0]           i_epsilon,
  output logic                  o_valid,
  output logic [ACT_W-1:0]      o_action,
  output logic [DATA_WIDTH-1:0] o_max_q,
  output logic                  o_explore,
  output logic                  o_busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_EMIT  = 2'd2;

  localparam logic [ACT_W-1:0] LAST_IDX = ACT_W'(NUM_ACTIONS - 1);

  logic [1:0]       state_q, state_d;
  logic [ACT_W-1:0] cnt_q, cnt_d;
  fp32_t            best_val_q, best_val_d;
  logic [ACT_W-1:0] best_idx_q, best_idx_d;
  logic [ACT_W-1:0] action_q, action_d;
  fp32_t            max_val_q, max_val_d;
  logic             explore_q, explore_d;

  logic             new_wins, take_new;
  fp32_t            cand_val;
  logic [ACT_W-1:0] cand_idx;
  logic             explore_pick;
  logic [ACT_W-1:0] rand_idx;

  fp32_gt u_gt (
    .a  (i_data),
    .b  (best_val_q),
    .gt (new_wins)
  );

  // The incoming beat is folded in combinationally, so the last beat lands directly in the result.
  assign take_new = (cnt_q == '0) || new_wins;
  assign cand_val = take_new ? i_data : best_val_q;
  assign cand_idx = take_new ? cnt_q  : best_idx_q;

`ifdef ACTION_EPSILON_GREEDY_EN
  logic [15:0]      lfsr_q, lfsr_d;
  logic [ACT_W-1:0] rr_q, rr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    rr_d   = (rr_q == LAST_IDX) ? '0 : rr_q + ACT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
      rr_q   <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      rr_q   <= rr_d;
    end
  end

  assign explore_pick = lfsr_q < i_epsilon;
  assign rand_idx     = rr_q;
`else
  logic unused_epsilon;
  assign unused_epsilon = ^i_epsilon;
  assign explore_pick   = 1'b0;
  assign rand_idx       = '0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    action_d   = action_q;
    max_val_d  = max_val_q;
    explore_d  = explore_q;
    if (i_clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (i_valid) begin
      best_val_d = cand_val;
      best_idx_d = cand_idx;
      if (cnt_q == LAST_IDX) begin
        state_d   = S_EMIT;
        cnt_d     = '0;
        max_val_d = cand_val;
        action_d  = explore_pick ? rand_idx : cand_idx;
        explore_d = explore_pick;
      end else begin
        state_d = S_ACCUM;
        cnt_d   = cnt_q + ACT_W'(1);
      end
    end else if (state_q == S_EMIT) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      best_val_q <= FP32_NEG_INF;
      best_idx_q <= '0;
      action_q   <= '0;
      max_val_q  <= FP32_NEG_INF;
      explore_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      action_q   <= action_d;
      max_val_q  <= max_val_d;
      explore_q  <= explore_d;
    end
  end

  assign o_valid   = (state_q == S_EMIT);
  assign o_busy    = (state_q == S_ACCUM);
  assign o_action  = action_q;
  assign o_max_q   = max_val_q;
  assign o_explore = explore_q;

endmodule
